// File: rtl/lsu_ctrl.sv
// Load/store control stage in front of the byte-addressable data memory: checks each request,
// drives the memory port for one cycle, extends load data and returns a registered response.
module lsu_ctrl #(
  parameter int MEMSIZE          = 'h400,
  parameter int DWIDTH           = 32,
  parameter int ALLOW_MISALIGNED = 1,
  localparam int WIDTH           = $clog2(MEMSIZE)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wen,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [DWIDTH-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DWIDTH-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              mem_en,
  output logic              mem_wen,
  output logic [WIDTH-1:0]  mem_addr,
  output logic [2:0]        mem_data_in_w,
  output logic [DWIDTH-1:0] mem_wdata,
  input  logic [DWIDTH-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

  localparam logic [WIDTH+1:0] MEM_LIMIT = (WIDTH+2)'(MEMSIZE);

  state_e            state_q, state_d;
  logic              wen_q, wen_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [WIDTH-1:0]  addr_q, addr_d;
  logic [DWIDTH-1:0] wdata_q, wdata_d;
  logic              err_q, err_d;
  logic [DWIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;

  logic [WIDTH+1:0]  req_size;
  logic [WIDTH+1:0]  req_end;
  logic              funct3_bad, range_bad, align_bad, req_err;
  logic              accept;
  logic [DWIDTH-1:0] load_data;

  // Fault classification of the incoming request, used only at the capture edge.
  always_comb begin
    req_size = '0;
    case (req_funct3[1:0])
      2'b00:   req_size = (WIDTH+2)'(1);
      2'b01:   req_size = (WIDTH+2)'(2);
      2'b10:   req_size = (WIDTH+2)'(4);
      default: req_size = '0;
    endcase
    if (req_wen) funct3_bad = req_funct3[2] || (req_funct3[1:0] == 2'b11);
    else         funct3_bad = (req_funct3[1:0] == 2'b11) || (req_funct3 == 3'b110);
    req_end   = {2'b00, req_addr[WIDTH-1:0]} + req_size;
    range_bad = (req_addr[31:WIDTH] != '0) || (req_end > MEM_LIMIT);
    align_bad = (ALLOW_MISALIGNED == 0) &&
                (((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                 ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00)));
    req_err   = funct3_bad || range_bad || align_bad;
  end

  always_comb begin
    load_data = mem_rdata;
    case (funct3_q)
      3'b000:  load_data = {{(DWIDTH-8){mem_rdata[7]}}, mem_rdata[7:0]};
      3'b100:  load_data = {{(DWIDTH-8){1'b0}}, mem_rdata[7:0]};
      3'b001:  load_data = {{(DWIDTH-16){mem_rdata[15]}}, mem_rdata[15:0]};
      3'b101:  load_data = {{(DWIDTH-16){1'b0}}, mem_rdata[15:0]};
      default: load_data = mem_rdata;
    endcase
  end

  assign req_ready = (state_q == IDLE) || ((state_q == RESP) && rsp_ready);
  assign accept    = req_valid && req_ready;

  always_comb begin
    state_d     = state_q;
    wen_d       = wen_q;
    funct3_d    = funct3_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    err_d       = err_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      ACCESS: begin
        rsp_err_d   = err_q;
        rsp_rdata_d = (err_q || wen_q) ? '0 : load_data;
        state_d     = RESP;
      end
      RESP: if (rsp_ready) state_d = IDLE;
      default: state_d = state_q;
    endcase
    // A new capture also covers the back-to-back case out of RESP.
    if (accept) begin
      wen_d    = req_wen;
      funct3_d = req_funct3;
      addr_d   = req_addr[WIDTH-1:0];
      wdata_d  = req_wdata;
      err_d    = req_err;
      state_d  = ACCESS;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      wen_q       <= 1'b0;
      funct3_q    <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      err_q       <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wen_q       <= wen_d;
      funct3_q    <= funct3_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      err_q       <= err_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Reset gates the enable so a store caught in ACCESS never commits.
  assign mem_en        = (state_q == ACCESS) && !err_q && !reset;
  assign mem_wen       = mem_en && wen_q;
  assign mem_addr      = addr_q;
  assign mem_data_in_w = {1'b0, funct3_q[1:0]};
  assign mem_wdata     = wdata_q;
  assign rsp_valid     = (state_q == RESP);
  assign rsp_rdata     = rsp_rdata_q;
  assign rsp_err       = rsp_err_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: two instances (misaligned allowed / forbidden) share stimulus and are
// checked every cycle against a request-level model with its own byte memory.
module tb_lsu_ctrl;
  localparam int MEMSIZE = 'h400;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_wen = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_ready = 1'b1;

  logic        req_ready [2];
  logic        rsp_valid [2];
  logic        rsp_err [2];
  logic        mem_en [2];
  logic        mem_wen [2];
  logic [31:0] rsp_rdata [2];
  logic [31:0] mem_wdata [2];
  logic [31:0] mem_rdata [2];
  logic [9:0]  mem_addr [2];
  logic [2:0]  mem_data_in_w [2];

  logic [7:0]  env_mem [2][MEMSIZE];
  logic [7:0]  ref_mem [2][MEMSIZE];

  typedef struct {
    logic            wen;
    logic [2:0]      f3;
    logic [31:0]     addr;
    logic [31:0]     wdata;
    logic [1:0]      err;
    logic [1:0][31:0] rdata;
    int              vfrom;
  } exp_t;

  exp_t        q[$];
  int          cycle_cnt = 0;
  int          checks_total = 0;
  int          checks_passed = 0;
  int          acc_count = 0;
  int          rsp_seen = 0;
  int          en_count [2] = '{0, 0};
  logic [31:0] last_rdata [2];
  logic        last_err [2];
  logic        post_reset = 1'b0;

  lsu_ctrl #(.MEMSIZE(MEMSIZE), .DWIDTH(32), .ALLOW_MISALIGNED(1)) dut_mis (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready[0]), .req_wen(req_wen),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]),
    .mem_en(mem_en[0]), .mem_wen(mem_wen[0]), .mem_addr(mem_addr[0]),
    .mem_data_in_w(mem_data_in_w[0]), .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0])
  );

  lsu_ctrl #(.MEMSIZE(MEMSIZE), .DWIDTH(32), .ALLOW_MISALIGNED(0)) dut_aln (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready[1]), .req_wen(req_wen),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]),
    .mem_en(mem_en[1]), .mem_wen(mem_wen[1]), .mem_addr(mem_addr[1]),
    .mem_data_in_w(mem_data_in_w[1]), .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1])
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  function automatic logic [7:0] init_byte(input int j);
    return 8'((j * 37 + 11) ^ (j >> 3));
  endfunction

  function automatic int access_size(input logic [1:0] code);
    case (code)
      2'd0:    return 1;
      2'd1:    return 2;
      2'd2:    return 4;
      default: return 0;
    endcase
  endfunction

  // Stand-in for the data memory: combinational read, write on the clock edge.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (cycle_cnt == 0) begin
        for (int j = 0; j < MEMSIZE; j++) env_mem[k][j] <= init_byte(j);
      end else if (mem_en[k] && mem_wen[k]) begin
        for (int i = 0; i < 4; i++)
          if (i < access_size(mem_data_in_w[k][1:0]))
            env_mem[k][(int'(mem_addr[k]) + i) % MEMSIZE] <= mem_wdata[k][8*i +: 8];
      end
    end
  end

  always_comb begin
    mem_rdata[0] = '0;
    mem_rdata[1] = '0;
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 4; i++)
        mem_rdata[k][8*i +: 8] = env_mem[k][(int'(mem_addr[k]) + i) % MEMSIZE];
  end

  function automatic logic model_err(input int k, input logic wen, input logic [2:0] f3,
                                     input logic [31:0] addr);
    int  size;
    logic bad;
    size = access_size(f3[1:0]);
    bad  = wen ? !(f3 <= 3'd2) : !(f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    if (addr >= 32'(MEMSIZE))              bad = 1'b1;
    else if (int'(addr) + size > MEMSIZE)  bad = 1'b1;
    if (k == 1 && size > 1 && (addr % 32'(size)) != 0) bad = 1'b1;
    return bad;
  endfunction

  function automatic logic [31:0] model_load(input int k, input logic [2:0] f3, input logic [31:0] addr);
    int b [4];
    int v;
    for (int i = 0; i < 4; i++) b[i] = int'(ref_mem[k][(int'(addr[9:0]) + i) % MEMSIZE]);
    case (f3)
      3'd0:    v = (b[0] < 128) ? b[0] : b[0] - 256;
      3'd4:    v = b[0];
      3'd1:    begin v = b[0] + 256 * b[1]; if (v >= 32768) v = v - 65536; end
      3'd5:    v = b[0] + 256 * b[1];
      default: v = b[0] + (b[1] << 8) + (b[2] << 16) + (b[3] << 24);
    endcase
    return 32'(v);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks_total++;
    if (actual === expected) checks_passed++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
  endtask

  // Reference model and per-cycle comparison; model updates describe the upcoming edge.
  always @(negedge clk) begin : monitor
    logic busy, exp_valid, in_acc, exp_en, exp_rr;
    exp_t e;
    exp_t n;
    if (cycle_cnt == 1)
      for (int k = 0; k < 2; k++)
        for (int j = 0; j < MEMSIZE; j++) ref_mem[k][j] = init_byte(j);
    busy = (q.size() > 0);
    if (busy) e = q[0];
    exp_valid = busy && (cycle_cnt >= e.vfrom);
    in_acc    = busy && (cycle_cnt == e.vfrom - 1);
    exp_rr    = !busy || (exp_valid && rsp_ready);
    for (int k = 0; k < 2; k++) begin
      exp_en = in_acc && !e.err[k] && !reset;
      checkOutput($sformatf("req_ready[%0d]", k), 32'(req_ready[k]), 32'(exp_rr));
      checkOutput($sformatf("mem_en[%0d]", k), 32'(mem_en[k]), 32'(exp_en));
      checkOutput($sformatf("mem_wen[%0d]", k), 32'(mem_wen[k]), 32'(exp_en && e.wen));
      if (mem_en[k]) en_count[k]++;
      if (exp_en) begin
        checkOutput($sformatf("mem_addr[%0d]", k), 32'(mem_addr[k]), 32'(e.addr[9:0]));
        checkOutput($sformatf("mem_width[%0d]", k), 32'(mem_data_in_w[k]), 32'({1'b0, e.f3[1:0]}));
        checkOutput($sformatf("mem_wdata[%0d]", k), mem_wdata[k], e.wdata);
      end
      if (in_acc && !reset) begin
        if (e.err[k] || e.wen) e.rdata[k] = '0;
        else                   e.rdata[k] = model_load(k, e.f3, e.addr);
        if (!e.err[k] && e.wen)
          for (int i = 0; i < access_size(e.f3[1:0]); i++)
            ref_mem[k][int'(e.addr[9:0]) + i] = e.wdata[8*i +: 8];
      end
      checkOutput($sformatf("rsp_valid[%0d]", k), 32'(rsp_valid[k]), 32'(exp_valid));
      if (exp_valid) begin
        checkOutput($sformatf("rsp_rdata[%0d]", k), rsp_rdata[k], e.rdata[k]);
        checkOutput($sformatf("rsp_err[%0d]", k), 32'(rsp_err[k]), 32'(e.err[k]));
      end
      if (post_reset) begin
        checkOutput($sformatf("rst_rdata[%0d]", k), rsp_rdata[k], 32'h0);
        checkOutput($sformatf("rst_err[%0d]", k), 32'(rsp_err[k]), 32'h0);
        checkOutput($sformatf("rst_addr[%0d]", k), 32'(mem_addr[k]), 32'h0);
        checkOutput($sformatf("rst_wdata[%0d]", k), mem_wdata[k], 32'h0);
        checkOutput($sformatf("rst_width[%0d]", k), 32'(mem_data_in_w[k]), 32'h0);
      end
    end
    if (busy) q[0] = e;
    post_reset = reset;
    if (reset) begin
      q.delete();
    end else begin
      if (exp_valid && rsp_ready) begin
        for (int k = 0; k < 2; k++) begin
          last_rdata[k] = e.rdata[k];
          last_err[k]   = e.err[k];
        end
        void'(q.pop_front());
        rsp_seen++;
      end
      if (req_valid && exp_rr) begin
        n.wen   = req_wen;
        n.f3    = req_funct3;
        n.addr  = req_addr;
        n.wdata = req_wdata;
        n.err   = {model_err(1, req_wen, req_funct3, req_addr), model_err(0, req_wen, req_funct3, req_addr)};
        n.rdata = '0;
        n.vfrom = cycle_cnt + 2;
        q.push_back(n);
        acc_count++;
      end
    end
  end

  task automatic waitAccept();
    int   base = acc_count;
    logic ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(posedge clk); #1;
      if (acc_count != base) ok = 1'b1;
    end
    checkOutput("accept_within_bound", 32'(ok), 32'h1);
  endtask

  task automatic waitResponse();
    int   base = rsp_seen;
    logic ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(posedge clk); #1;
      if (rsp_seen != base) ok = 1'b1;
    end
    checkOutput("response_within_bound", 32'(ok), 32'h1);
  endtask

  task automatic applyStimulus(input logic wen, input logic [2:0] f3, input logic [31:0] addr,
                               input logic [31:0] wdata);
    req_wen    = wen;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    req_valid  = 1'b1;
    waitAccept();
    req_valid  = 1'b0;
    waitResponse();
  endtask

  task automatic expectRsp(input int k, input string name, input logic [31:0] rdata, input logic err);
    checkOutput({name, "_rdata"}, last_rdata[k], rdata);
    checkOutput({name, "_err"}, 32'(last_err[k]), 32'(err));
  endtask

  initial begin
    int e0, e1, a0, s0;
    repeat (4) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;

    applyStimulus(1'b1, 3'b010, 32'h010, 32'hDEADBEEF);
    expectRsp(0, "sw10_m", 32'h0, 1'b0);
    applyStimulus(1'b0, 3'b010, 32'h010, 32'h0);
    expectRsp(0, "lw10_m", 32'hDEADBEEF, 1'b0);
    expectRsp(1, "lw10_a", 32'hDEADBEEF, 1'b0);

    applyStimulus(1'b1, 3'b000, 32'h020, 32'h0000005A);
    applyStimulus(1'b1, 3'b000, 32'h021, 32'hFFFFFF80);
    applyStimulus(1'b0, 3'b000, 32'h021, 32'h0);
    expectRsp(0, "lb21", 32'hFFFFFF80, 1'b0);
    applyStimulus(1'b0, 3'b100, 32'h021, 32'h0);
    expectRsp(1, "lbu21", 32'h00000080, 1'b0);
    applyStimulus(1'b0, 3'b001, 32'h020, 32'h0);
    expectRsp(0, "lh20", 32'hFFFF805A, 1'b0);

    applyStimulus(1'b1, 3'b010, 32'h000, 32'h11223344);
    e0 = en_count[0];
    e1 = en_count[1];
    applyStimulus(1'b1, 3'b001, 32'h003, 32'h0000BEEF);
    expectRsp(0, "sh3_m", 32'h0, 1'b0);
    expectRsp(1, "sh3_a", 32'h0, 1'b1);
    checkOutput("sh3_m_en_pulses", 32'(en_count[0] - e0), 32'd1);
    checkOutput("sh3_a_en_pulses", 32'(en_count[1] - e1), 32'd0);
    applyStimulus(1'b0, 3'b010, 32'h000, 32'h0);
    expectRsp(0, "lw0_m", 32'hEF223344, 1'b0);
    expectRsp(1, "lw0_a", 32'h11223344, 1'b0);

    applyStimulus(1'b0, 3'b010, 32'h3FE, 32'h0);
    expectRsp(0, "lw3fe", 32'h0, 1'b1);
    applyStimulus(1'b0, 3'b000, 32'h3FF, 32'h0);
    checkOutput("lb3ff_err", 32'(last_err[0]), 32'h0);
    applyStimulus(1'b0, 3'b010, 32'h3FC, 32'h0);
    checkOutput("lw3fc_err", 32'(last_err[1]), 32'h0);
    applyStimulus(1'b0, 3'b010, 32'h400, 32'h0);
    expectRsp(1, "lw400", 32'h0, 1'b1);
    applyStimulus(1'b0, 3'b011, 32'h000, 32'h0);
    expectRsp(0, "f3_011", 32'h0, 1'b1);

    // Response stall followed by a back-to-back accept out of RESP.
    req_wen = 1'b0; req_funct3 = 3'b010; req_addr = 32'h010; req_valid = 1'b1;
    waitAccept();
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    @(posedge clk); #1;
    req_funct3 = 3'b100; req_addr = 32'h021; req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("stall_valid", 32'(rsp_valid[0]), 32'h1);
      checkOutput("stall_rdata", rsp_rdata[1], 32'hDEADBEEF);
      checkOutput("stall_req_ready", 32'(req_ready[0]), 32'h0);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    a0 = acc_count;
    s0 = rsp_seen;
    @(negedge clk);
    checkOutput("b2b_req_ready", 32'(req_ready[0]), 32'h1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    checkOutput("b2b_accepts", 32'(acc_count - a0), 32'd1);
    checkOutput("b2b_responses", 32'(rsp_seen - s0), 32'd1);
    expectRsp(0, "stalled_lw", 32'hDEADBEEF, 1'b0);
    waitResponse();
    expectRsp(1, "b2b_lbu", 32'h00000080, 1'b0);

    // Reset during the ACCESS cycle of a store.
    applyStimulus(1'b1, 3'b010, 32'h040, 32'h0BADF00D);
    req_wen = 1'b1; req_funct3 = 3'b010; req_addr = 32'h040; req_wdata = 32'h12345678; req_valid = 1'b1;
    waitAccept();
    reset = 1'b1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    checkOutput("rst_rsp_valid", 32'(rsp_valid[0]), 32'h0);
    checkOutput("rst_rsp_rdata", rsp_rdata[0], 32'h0);
    checkOutput("rst_mem_en", 32'(mem_en[1]), 32'h0);
    checkOutput("rst_req_ready", 32'(req_ready[1]), 32'h1);
    checkOutput("rst_mem_addr", 32'(mem_addr[0]), 32'h0);
    applyStimulus(1'b0, 3'b010, 32'h040, 32'h0);
    expectRsp(0, "lw40_after_rst", 32'h0BADF00D, 1'b0);
    expectRsp(1, "lw40_after_rst_a", 32'h0BADF00D, 1'b0);

    for (int c = 0; c < 1500; c++) begin
      reset      = ($urandom_range(0, 149) == 0);
      req_valid  = $urandom_range(0, 1) == 1;
      req_wen    = $urandom_range(0, 1) == 1;
      req_funct3 = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 9))
        0:       req_addr = 32'h3F8 + 32'($urandom_range(0, 15));
        1:       req_addr = $urandom;
        default: req_addr = 32'($urandom_range(0, MEMSIZE - 1));
      endcase
      req_wdata  = $urandom;
      rsp_ready  = $urandom_range(0, 9) < 7;
      @(posedge clk); #1;
    end
    reset = 1'b0;
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk); #1;
    $display("[TB] %0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
